button_debounce: RTL

Multi-bit pushbutton/switch input conditioner: the input-side counterpart to the LED output driver. It synchronises asynchronous board buttons into `clk`, debounces each bit independently with a per-bit stability counter, and emits a stable level plus one-cycle press and release strobes. With `BUTTON_DEBOUNCE_LONG_PRESS_EN` defined, it also emits a one-cycle long-press strobe. It sits directly behind the top-level button pins and feeds user logic. Top-level designs compute counter widths from clock frequency, so the block takes integer widths only.

---
 rtl/button_debounce.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/button_debounce.sv
// Multi-bit pushbutton conditioner: polarity fix, 2-flop sync, per-bit debounce, press/release strobes.
// Optional per-bit long-press strobe is built when BUTTON_DEBOUNCE_LONG_PRESS_EN is defined.
module button_debounce #(
    parameter int BTN_WIDTH      = 4,
    parameter int DB_CNT_WIDTH   = 20,
    parameter int LONG_WIDTH     = 26,
    parameter int BTN_ACTIVE_LOW = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BTN_WIDTH-1:0] btn_in,
    output logic [BTN_WIDTH-1:0] btn_state,
    output logic [BTN_WIDTH-1:0] btn_press,
    output logic [BTN_WIDTH-1:0] btn_release,
    output logic [BTN_WIDTH-1:0] btn_long
);

    typedef enum logic {
        STABLE_0 = 1'b0,
        STABLE_1 = 1'b1
    } dbState_e;

    localparam logic [DB_CNT_WIDTH-1:0] DB_CNT_MAX = '1;

    // Widths come from clock-frequency arithmetic upstream; a zero width is a top-level bug.
    if (BTN_WIDTH < 1 || DB_CNT_WIDTH < 1 || LONG_WIDTH < 1) begin : gBadParams
        $error("button_debounce: all widths must be at least 1");
    end

    logic [BTN_WIDTH-1:0]    btnNorm;
    logic [BTN_WIDTH-1:0]    sync1_q;
    logic [BTN_WIDTH-1:0]    sync2_q;
    dbState_e                dbState_q [BTN_WIDTH];
    dbState_e                dbState_d [BTN_WIDTH];
    logic [DB_CNT_WIDTH-1:0] dbCnt_q   [BTN_WIDTH];
    logic [DB_CNT_WIDTH-1:0] dbCnt_d   [BTN_WIDTH];
    logic [BTN_WIDTH-1:0]    press_q;
    logic [BTN_WIDTH-1:0]    press_d;
    logic [BTN_WIDTH-1:0]    release_q;
    logic [BTN_WIDTH-1:0]    release_d;

    assign btnNorm = (BTN_ACTIVE_LOW != 0) ? ~btn_in : btn_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btnNorm;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BTN_WIDTH; i++) begin
                dbState_q[i] <= STABLE_0;
                dbCnt_q[i]   <= '0;
            end
            press_q   <= '0;
            release_q <= '0;
        end else begin
            for (int i = 0; i < BTN_WIDTH; i++) begin
                dbState_q[i] <= dbState_d[i];
                dbCnt_q[i]   <= dbCnt_d[i];
            end
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    always_comb begin
        btn_state = '0;
        for (int i = 0; i < BTN_WIDTH; i++) begin
            btn_state[i] = (dbState_q[i] == STABLE_1);
        end
    end

    // Any sample agreeing with the current level restarts the count, so bounce never accumulates.
    always_comb begin
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < BTN_WIDTH; i++) begin
            dbState_d[i] = dbState_q[i];
            dbCnt_d[i]   = dbCnt_q[i];
            if (sync2_q[i] == btn_state[i]) begin
                dbCnt_d[i] = '0;
            end else if (dbCnt_q[i] == DB_CNT_MAX) begin
                dbCnt_d[i]   = '0;
                dbState_d[i] = sync2_q[i] ? STABLE_1 : STABLE_0;
                press_d[i]   = sync2_q[i];
                release_d[i] = ~sync2_q[i];
            end else begin
                dbCnt_d[i] = dbCnt_q[i] + 1'b1;
            end
        end
    end

    assign btn_press   = press_q;
    assign btn_release = release_q;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    localparam logic [LONG_WIDTH-1:0] LONG_MAX = '1;
    localparam logic [LONG_WIDTH-1:0] LONG_PRE = LONG_MAX - 1'b1;

    logic [LONG_WIDTH-1:0] longCnt_q [BTN_WIDTH];
    logic [LONG_WIDTH-1:0] longCnt_d [BTN_WIDTH];
    logic [BTN_WIDTH-1:0]  long_q;
    logic [BTN_WIDTH-1:0]  long_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BTN_WIDTH; i++) begin
                longCnt_q[i] <= '0;
            end
            long_q <= '0;
        end else begin
            for (int i = 0; i < BTN_WIDTH; i++) begin
                longCnt_q[i] <= longCnt_d[i];
            end
            long_q <= long_d;
        end
    end

    // The counter saturates, so the pulse fires once per press; a release edge suppresses it.
    always_comb begin
        long_d = '0;
        for (int i = 0; i < BTN_WIDTH; i++) begin
            longCnt_d[i] = longCnt_q[i];
            if (!btn_state[i] || release_d[i]) begin
                longCnt_d[i] = '0;
            end else if (longCnt_q[i] != LONG_MAX) begin
                longCnt_d[i] = longCnt_q[i] + 1'b1;
                long_d[i]    = (longCnt_q[i] == LONG_PRE);
            end
        end
    end

    assign btn_long = long_q;
`else
    assign btn_long = '0;
`endif

endmodule
